// File: rtl/alu_fp_seq.sv
// Multi-cycle FP32/FP16 add/sub/mul/div with valid/ready handshakes, RNE rounding and a
// restoring divider. FP16 significands are left-aligned into the FP32 datapath.
module alu_fp_seq #(
    parameter int DIV_BITS = 1,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [1:0]       op_code,
    input  logic             mode_fp,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [4:0]       flags,
    output logic [TAG_W-1:0] tag_out
);
    // state  | meaning
    // IDLE   | waiting for an operation
    // UNPACK | classify operands, resolve special cases, seed divider
    // EXEC   | align+add, multiply, or iterate divider
    // ROUND  | normalise, round, range check, register outputs
    // DONE   | result valid, held until out_ready
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_ROUND, S_DONE} state_t;
    localparam int DIV_CYC = 26 / DIV_BITS;

    state_t r_state, w_next;
    logic [31:0] r_a, r_b, r_spec_res;
    logic [1:0]  r_op;
    logic        r_fp16, r_spec, r_sign;
    logic [TAG_W-1:0] r_tag;
    logic [4:0]  r_spec_flags, r_cnt;
    logic signed [9:0] r_exp;
    logic [47:0] r_man;
    logic [25:0] r_q;
    logic [26:0] r_rem;

    function automatic logic [31:0] f_sgn(input logic fp16, input logic s, input logic [30:0] mag);
        return fp16 ? {16'b0, s, mag[14:0]} : {s, mag};
    endfunction

    logic w_accept;
    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);

    logic [7:0]  w_ea, w_eb, w_emax_raw;
    logic [23:0] w_ma, w_mb;
    logic        w_sa, w_sb, w_sbe, w_sx, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic signed [9:0] w_bias;
    logic [30:0] w_inf, w_nan;
    assign w_ea       = r_fp16 ? {3'b0, r_a[14:10]} : r_a[30:23];
    assign w_eb       = r_fp16 ? {3'b0, r_b[14:10]} : r_b[30:23];
    assign w_ma       = r_fp16 ? {1'b1, r_a[9:0], 13'b0} : {1'b1, r_a[22:0]};
    assign w_mb       = r_fp16 ? {1'b1, r_b[9:0], 13'b0} : {1'b1, r_b[22:0]};
    assign w_sa       = r_fp16 ? r_a[15] : r_a[31];
    assign w_sb       = r_fp16 ? r_b[15] : r_b[31];
    assign w_sbe      = w_sb ^ (r_op == 2'b01);
    assign w_sx       = w_sa ^ w_sb;
    assign w_emax_raw = r_fp16 ? 8'd31 : 8'd255;
    assign w_za       = (w_ea == 8'd0);
    assign w_zb       = (w_eb == 8'd0);
    assign w_ia       = (w_ea == w_emax_raw) & (w_ma[22:0] == 23'd0);
    assign w_ib       = (w_eb == w_emax_raw) & (w_mb[22:0] == 23'd0);
    assign w_na       = (w_ea == w_emax_raw) & (w_ma[22:0] != 23'd0);
    assign w_nb       = (w_eb == w_emax_raw) & (w_mb[22:0] != 23'd0);
    assign w_bias     = r_fp16 ? 10'sd15 : 10'sd127;
    assign w_inf      = r_fp16 ? 31'h7C00 : 31'h7F800000;
    assign w_nan      = r_fp16 ? 31'h7E00 : 31'h7FC00000;

    logic        w_is_spec;
    logic [31:0] w_spec_res;
    logic [4:0]  w_spec_flags;
    always_comb begin
        w_is_spec    = 1'b1;
        w_spec_res   = 32'd0;
        w_spec_flags = 5'd0;
        if (w_na | w_nb) begin
            w_spec_res = {1'b0, w_nan}; w_spec_flags = 5'b10000;
        end else if (r_op[1] == 1'b0) begin
            if (w_ia & w_ib & (w_sa != w_sbe)) begin
                w_spec_res = {1'b0, w_nan}; w_spec_flags = 5'b10000;
            end else if (w_ia)        w_spec_res = f_sgn(r_fp16, w_sa, w_inf);
            else if (w_ib)            w_spec_res = f_sgn(r_fp16, w_sbe, w_inf);
            else if (w_za & w_zb)     w_spec_res = f_sgn(r_fp16, w_sa & w_sbe, 31'd0);
            else if (w_za)            w_spec_res = f_sgn(r_fp16, w_sbe, r_b[30:0]);
            else if (w_zb)            w_spec_res = f_sgn(r_fp16, w_sa, r_a[30:0]);
            else                      w_is_spec  = 1'b0;
        end else if (r_op == 2'b10) begin
            if ((w_ia | w_ib) & (w_za | w_zb)) begin
                w_spec_res = {1'b0, w_nan}; w_spec_flags = 5'b10000;
            end else if (w_ia | w_ib) w_spec_res = f_sgn(r_fp16, w_sx, w_inf);
            else if (w_za | w_zb)     w_spec_res = f_sgn(r_fp16, w_sx, 31'd0);
            else                      w_is_spec  = 1'b0;
        end else begin
            if ((w_za & w_zb) | (w_ia & w_ib)) begin
                w_spec_res = {1'b0, w_nan}; w_spec_flags = 5'b10000;
            end else if (w_ia)        w_spec_res = f_sgn(r_fp16, w_sx, w_inf);
            else if (w_zb) begin
                w_spec_res = f_sgn(r_fp16, w_sx, w_inf); w_spec_flags = 5'b01000;
            end else if (w_za | w_ib) w_spec_res = f_sgn(r_fp16, w_sx, 31'd0);
            else                      w_is_spec  = 1'b0;
        end
    end

    // Add/sub: larger magnitude sits with its leading one at bit 46; the smaller is
    // shifted right with every lost bit folded into a sticky jam at bit 0.
    logic        w_a_big, w_sign_big, w_st;
    logic [7:0]  w_big_e, w_d;
    logic [23:0] w_big_m, w_sml_m;
    logic [46:0] w_ext, w_aligned;
    logic [47:0] w_opa, w_opb, w_sum, w_prod;
    always_comb begin
        w_a_big    = {w_ea, w_ma} >= {w_eb, w_mb};
        w_big_e    = w_a_big ? w_ea : w_eb;
        w_big_m    = w_a_big ? w_ma : w_mb;
        w_sml_m    = w_a_big ? w_mb : w_ma;
        w_sign_big = w_a_big ? w_sa : w_sbe;
        w_d        = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
        w_ext      = {w_sml_m, 23'b0};
        if (w_d >= 8'd47) begin
            w_aligned = 47'd0;
            w_st      = 1'b1;
        end else begin
            w_aligned = w_ext >> w_d;
            w_st      = |(w_ext & ~({47{1'b1}} << w_d));
        end
        w_opa  = {1'b0, w_big_m, 23'b0};
        w_opb  = {1'b0, w_aligned} | {47'd0, w_st};
        w_sum  = (w_sa == w_sbe) ? (w_opa + w_opb) : (w_opa - w_opb);
        w_prod = w_ma * w_mb;
    end

    // Dividend pre-scaled so the quotient always lies in [1,2).
    logic        w_pre;
    logic [26:0] w_rem0, w_rem_nxt;
    logic [25:0] w_q_nxt;
    assign w_pre  = (w_ma < w_mb);
    assign w_rem0 = w_pre ? {2'b0, w_ma, 1'b0} : {3'b0, w_ma};
    always_comb begin
        w_rem_nxt = r_rem;
        w_q_nxt   = r_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            if (w_rem_nxt >= {3'b0, w_mb}) begin
                w_rem_nxt = w_rem_nxt - {3'b0, w_mb};
                w_q_nxt   = {w_q_nxt[24:0], 1'b1};
            end else begin
                w_q_nxt   = {w_q_nxt[24:0], 1'b0};
            end
            w_rem_nxt = w_rem_nxt << 1;
        end
    end

    logic [47:0] w_rman, w_nm;
    logic [5:0]  w_p;
    logic [23:0] w_kept, w_rnd;
    logic        w_g, w_r, w_s, w_carry;
    logic signed [9:0] w_exp_n, w_exp_f, w_emax;
    logic [31:0] w_res;
    logic [4:0]  w_flg;
    always_comb begin
        w_rman = (r_op == 2'b11) ? ({1'b0, r_q, 21'b0} | {47'd0, r_rem != 27'd0}) : r_man;
        w_p = 6'd0;
        for (int i = 0; i < 48; i++)
            if (w_rman[i]) w_p = i[5:0];
        w_nm    = w_rman << (6'd47 - w_p);
        w_exp_n = r_exp + $signed({4'b0, w_p}) - 10'sd46;
        w_kept  = r_fp16 ? {13'b0, w_nm[47:37]} : w_nm[47:24];
        w_g     = r_fp16 ? w_nm[36] : w_nm[23];
        w_r     = r_fp16 ? w_nm[35] : w_nm[22];
        w_s     = r_fp16 ? |w_nm[34:0] : |w_nm[21:0];
        w_rnd   = w_kept + {23'd0, w_g & (w_r | w_s | w_kept[0])};
        // A rounding carry wraps the hidden bit to zero.
        w_carry = ~(r_fp16 ? w_rnd[10] : w_rnd[23]);
        w_exp_f = w_exp_n + $signed({9'd0, w_carry});
        w_emax  = r_fp16 ? 10'sd30 : 10'sd254;
        w_res   = 32'd0;
        w_flg   = 5'd0;
        if (w_rman == 48'd0) begin
            w_res = 32'd0;
        end else if (w_exp_f > w_emax) begin
            w_res = f_sgn(r_fp16, r_sign, w_inf); w_flg = 5'b00101;
        end else if (w_exp_f < 10'sd1) begin
            w_res = f_sgn(r_fp16, r_sign, 31'd0); w_flg = 5'b00011;
        end else begin
            w_res = r_fp16 ? {16'b0, r_sign, w_exp_f[4:0], w_rnd[9:0]}
                           : {r_sign, w_exp_f[7:0], w_rnd[22:0]};
            w_flg = {4'b0, w_g | w_r | w_s};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_UNPACK;
            S_UNPACK: w_next = w_is_spec ? S_ROUND : S_EXEC;
            S_EXEC:   if (r_op != 2'b11 || r_cnt == 5'd0) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   if (out_ready) w_next = in_valid ? S_UNPACK : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_fp16 <= 1'b0; r_tag <= '0;
            r_spec <= 1'b0; r_spec_res <= '0; r_spec_flags <= '0;
            r_sign <= 1'b0; r_exp <= '0; r_man <= '0; r_q <= '0; r_rem <= '0; r_cnt <= '0;
            result <= '0; flags <= '0; tag_out <= '0;
        end else begin
            if (w_accept) begin
                r_a <= op_a; r_b <= op_b; r_op <= op_code; r_fp16 <= mode_fp; r_tag <= tag_in;
            end
            case (r_state)
                S_UNPACK: begin
                    r_spec       <= w_is_spec;
                    r_spec_res   <= w_spec_res;
                    r_spec_flags <= w_spec_flags;
                    r_sign       <= w_sx;
                    r_exp        <= $signed({2'b0, w_ea}) - $signed({2'b0, w_eb}) + w_bias
                                    - $signed({9'd0, w_pre});
                    r_rem        <= w_rem0;
                    r_q          <= '0;
                    r_cnt        <= 5'(DIV_CYC - 1);
                end
                S_EXEC: begin
                    if (r_op == 2'b11) begin
                        r_q <= w_q_nxt; r_rem <= w_rem_nxt; r_cnt <= r_cnt - 5'd1;
                    end else if (r_op == 2'b10) begin
                        r_man <= w_prod;
                        r_exp <= $signed({2'b0, w_ea}) + $signed({2'b0, w_eb}) - w_bias;
                    end else begin
                        r_man  <= w_sum;
                        r_exp  <= $signed({2'b0, w_big_e});
                        r_sign <= w_sign_big;
                    end
                end
                S_ROUND: begin
                    result  <= r_spec ? r_spec_res : w_res;
                    flags   <= r_spec ? r_spec_flags : w_flg;
                    tag_out <= r_tag;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_fp_seq.sv
// Directed bench for alu_fp_seq: arithmetic, specials, rounding, latency, backpressure, reset.
module tb_alu_fp_seq;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [31:0] op_a = '0, op_b = '0;
    logic [1:0]  op_code = '0;
    logic        mode_fp = 1'b0;
    logic [3:0]  tag_in = '0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] result, result2;
    logic [4:0]  flags, flags2;
    logic [3:0]  tag_out, tag_out2;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [31:0] a, b;
        logic [1:0]  op;
        logic        m;
        logic [31:0] res;
        logic [4:0]  flg;
        logic [5:0]  lat;
    } vec_t;

    alu_fp_seq #(.DIV_BITS(1), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .mode_fp(mode_fp), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
        .tag_out(tag_out));

    alu_fp_seq #(.DIV_BITS(2), .TAG_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .mode_fp(mode_fp), .tag_in(tag_in),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .flags(flags2),
        .tag_out(tag_out2));

    always #5 clk = ~clk;

    task automatic wait_result(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic m, input logic [3:0] t, output int lat);
        int n = 0;
        @(negedge clk);
        op_a = a; op_b = b; op_code = op; mode_fp = m; tag_in = t; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_code = 2'($urandom); tag_in = 4'hF;
        wait_result(lat);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (flags !== 5'd0) begin errors++; $display("FAIL reset_flags: got %b want 0", flags); end
        checks++; if (tag_out !== 4'd0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        vec_t v[5];
        int lat;
        v[0] = '{32'h3F800000, 32'h40000000, 2'd0, 1'b0, 32'h40400000, 5'b00000, 6'd3};
        v[1] = '{32'h3F800000, 32'h33800000, 2'd0, 1'b0, 32'h3F800000, 5'b00001, 6'd3};
        v[2] = '{32'h40400000, 32'h3F800000, 2'd1, 1'b0, 32'h40000000, 5'b00000, 6'd3};
        v[3] = '{32'h3F800000, 32'h3F800000, 2'd1, 1'b0, 32'h00000000, 5'b00000, 6'd3};
        v[4] = '{32'h00003C00, 32'h00003C00, 2'd0, 1'b1, 32'h00004000, 5'b00000, 6'd3};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, v[i].m, 4'(i + 5), lat);
            checks++; if (result !== v[i].res) begin errors++; $display("FAIL add%0d_res: got %h want %h", i, result, v[i].res); end
            checks++; if (flags !== v[i].flg) begin errors++; $display("FAIL add%0d_flags: got %b want %b", i, flags, v[i].flg); end
            checks++; if (tag_out !== 4'(i + 5)) begin errors++; $display("FAIL add%0d_tag: got %h want %h", i, tag_out, 4'(i + 5)); end
            checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL add%0d_lat: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_mul();
        vec_t v[4];
        int lat;
        v[0] = '{32'hFFFF3C00, 32'h0000C000, 2'd2, 1'b1, 32'h0000C000, 5'b00000, 6'd3};
        v[1] = '{32'h40400000, 32'h40400000, 2'd2, 1'b0, 32'h41100000, 5'b00000, 6'd3};
        v[2] = '{32'h7F7FFFFF, 32'h40000000, 2'd2, 1'b0, 32'h7F800000, 5'b00101, 6'd3};
        v[3] = '{32'h00800000, 32'h00800000, 2'd2, 1'b0, 32'h00000000, 5'b00011, 6'd3};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, v[i].m, 4'd2, lat);
            checks++; if (result !== v[i].res) begin errors++; $display("FAIL mul%0d_res: got %h want %h", i, result, v[i].res); end
            checks++; if (flags !== v[i].flg) begin errors++; $display("FAIL mul%0d_flags: got %b want %b", i, flags, v[i].flg); end
            checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL mul%0d_lat: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_specials();
        vec_t v[5];
        int lat;
        v[0] = '{32'h3F800000, 32'h00000000, 2'd3, 1'b0, 32'h7F800000, 5'b01000, 6'd2};
        v[1] = '{32'h7F800000, 32'h7F800000, 2'd1, 1'b0, 32'h7FC00000, 5'b10000, 6'd2};
        v[2] = '{32'h00000000, 32'h00000000, 2'd3, 1'b0, 32'h7FC00000, 5'b10000, 6'd2};
        v[3] = '{32'h80000000, 32'h80000000, 2'd0, 1'b0, 32'h80000000, 5'b00000, 6'd2};
        v[4] = '{32'h00007E01, 32'h00003C00, 2'd0, 1'b1, 32'h00007E00, 5'b10000, 6'd2};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, v[i].m, 4'd3, lat);
            checks++; if (result !== v[i].res) begin errors++; $display("FAIL spec%0d_res: got %h want %h", i, result, v[i].res); end
            checks++; if (flags !== v[i].flg) begin errors++; $display("FAIL spec%0d_flags: got %b want %b", i, flags, v[i].flg); end
            checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL spec%0d_lat: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_div();
        int lat, lat2;
        do_op(32'h3F800000, 32'h40400000, 2'd3, 1'b0, 4'd7, lat);
        checks++; if (result !== 32'h3EAAAAAB) begin errors++; $display("FAIL div_res: got %h want 3eaaaaab", result); end
        checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL div_flags: got %b want 00001", flags); end
        checks++; if (lat != 28) begin errors++; $display("FAIL div_lat: got %0d want 28", lat); end
        do_op(32'h40C00000, 32'h40400000, 2'd3, 1'b0, 4'd8, lat);
        checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL div6_res: got %h want 40000000", result); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL div6_flags: got %b want 00000", flags); end
        @(negedge clk);
        op_a = 32'h3F800000; op_b = 32'h40400000; op_code = 2'd3; mode_fp = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1; in_valid2 = 1'b0;
        lat2 = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid2) begin lat2 = n; break; end
        end
        checks++; if (lat2 != 15) begin errors++; $display("FAIL div2_lat: got %0d want 15", lat2); end
        checks++; if (result2 !== 32'h3EAAAAAB) begin errors++; $display("FAIL div2_res: got %h want 3eaaaaab", result2); end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        do_op(32'h3F800000, 32'h40000000, 2'd0, 1'b0, 4'd5, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL bp_lat: got %0d want 3", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h40400000 || tag_out !== 4'd5 || flags !== 5'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%h t=%h f=%b want v=1 r=40400000 t=5 f=0", c, out_valid, result, tag_out, flags);
            end
        end
        @(negedge clk);
        op_a = 32'h40000000; op_b = 32'h40400000; op_code = 2'd2; mode_fp = 1'b0; tag_in = 4'd9;
        in_valid = 1'b1; out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 32'h0; op_b = 32'h0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        wait_result(lat);
        checks++; if (result !== 32'h40C00000) begin errors++; $display("FAIL b2b_res: got %h want 40c00000", result); end
        checks++; if (tag_out !== 4'd9) begin errors++; $display("FAIL b2b_tag: got %h want 9", tag_out); end
        checks++; if (lat != 3) begin errors++; $display("FAIL b2b_lat: got %0d want 3", lat); end
    endtask

    task automatic test_reset_mid_div();
        bit seen = 1'b0;
        @(negedge clk);
        op_a = 32'h3F800000; op_b = 32'h40400000; op_code = 2'd3; mode_fp = 1'b0; tag_in = 4'd4;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdiv_valid: got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstdiv_result: got %h want 0", result); end
        checks++; if (tag_out !== 4'd0) begin errors++; $display("FAIL rstdiv_tag: got %h want 0", tag_out); end
        @(negedge clk); rst = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstdiv_stale: got out_valid=1 want no result"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstdiv_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_add();
        test_mul();
        test_specials();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
